// File: rtl/spi_exe_pkg.sv
// Shared constants, frame layout and FSM encodings for the SPI execution-unit master.
package spi_exe_pkg;

  localparam int unsigned BITS      = 20;
  localparam int unsigned CNT_W     = $clog2(BITS + 1);
  localparam int unsigned CS_W      = 3;

  localparam int unsigned ARGA_HI   = 19;
  localparam int unsigned ARGA_LO   = 16;
  localparam int unsigned ARGB_HI   = 15;
  localparam int unsigned ARGB_LO   = 12;
  localparam int unsigned OPER_HI   = 11;
  localparam int unsigned OPER_LO   = 8;
  localparam int unsigned RESULT_HI = 7;
  localparam int unsigned RESULT_LO = 4;
  localparam int unsigned FLAGS_HI  = 3;
  localparam int unsigned FLAGS_LO  = 0;

  localparam logic [CS_W-1:0] SLAVE_ID = CS_W'(3);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR   = 3'd1;
  localparam logic [2:0] GAP  = 3'd2;
  localparam logic [2:0] RD   = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  typedef logic [BITS-1:0] frame_t;

  // Write frame: operands in the top nibbles, response fields zero.
  function automatic frame_t make_frame(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] op);
    return {a, b, op, 8'h00};
  endfunction

endpackage

// File: rtl/spi_exe_master_sclk_gen.sv
// SCLK divider: CLK_DIV i_clk cycles per half-period, idle low while disabled.
module spi_sclk_gen
  #(parameter int unsigned CLK_DIV = 4)
  (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise_stb,
    output logic o_fall_stb
  );

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] cnt;
  logic             wrap_c;

  assign wrap_c     = i_en && (cnt == DIV_W'(CLK_DIV - 1));
  assign o_rise_stb = wrap_c && !o_sclk;
  assign o_fall_stb = wrap_c && o_sclk;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt    <= '0;
      o_sclk <= 1'b0;
    end else if (!i_en) begin
      cnt    <= '0;
      o_sclk <= 1'b0;
    end else begin
      cnt <= wrap_c ? '0 : cnt + DIV_W'(1);
      if (wrap_c) o_sclk <= !o_sclk;
    end
  end

endmodule

// File: rtl/spi_exe_master.sv
// SPI master for the execution unit: write frame, deselected gap, read-back frame, then result.
module spi_exe_master
  import spi_exe_pkg::*;
  #(parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 3)
  (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [3:0]      i_argA,
    input  logic [3:0]      i_argB,
    input  logic [3:0]      i_oper,
    output logic            o_busy,
    output logic            o_done,
    output logic [3:0]      o_result,
    output logic [3:0]      o_flags,
    output logic            o_err,
    output logic            o_sclk,
    output logic            o_mosi,
    input  logic            i_miso,
    output logic [CS_W-1:0] o_cs
  );

  logic [2:0]             state, state_nxt;
  logic [BITS-2:0]        tx;
  frame_t                 rx;
  logic [ARGA_HI:OPER_LO] echo;
  logic [CNT_W-1:0]       bit_cnt;
  frame_t                 ld_c;
  logic                   sclk_en_c, rise_stb, fall_stb;
  logic                   accept_c, frame_end_c, gap_end_c;

  assign sclk_en_c   = (state == WR) || (state == GAP) || (state == RD);
  assign accept_c    = (state == IDLE) && i_start && !o_busy;
  assign frame_end_c = fall_stb && (bit_cnt == CNT_W'(BITS));
  assign gap_end_c   = fall_stb && (bit_cnt == CNT_W'(GAP_CYCLES));

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (sclk_en_c),
    .o_sclk     (o_sclk),
    .o_rise_stb (rise_stb),
    .o_fall_stb (fall_stb)
  );

  // Frame to load: fresh operands at accept, the latched copy for the read frame.
  always_comb begin
    ld_c = make_frame(echo[ARGA_HI:ARGA_LO], echo[ARGB_HI:ARGB_LO], echo[OPER_HI:OPER_LO]);
    if (state == IDLE) ld_c = make_frame(i_argA, i_argB, i_oper);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c)    state_nxt = WR;
      WR:      if (frame_end_c) state_nxt = GAP;
      GAP:     if (gap_end_c)   state_nxt = RD;
      RD:      if (frame_end_c) state_nxt = DONE;
      DONE:                     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tx       <= '0;
      rx       <= '0;
      echo     <= '0;
      bit_cnt  <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
      o_flags  <= '0;
      o_err    <= 1'b0;
      o_mosi   <= 1'b0;
      o_cs     <= '0;
    end else begin
      o_done <= 1'b0;
      if (o_done) o_busy <= 1'b0;
      // Rises are counted per window; the counter saturates and never wraps.
      if (rise_stb && (bit_cnt != CNT_W'(BITS))) bit_cnt <= bit_cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (accept_c) begin
            echo    <= {i_argA, i_argB, i_oper};
            tx      <= ld_c[BITS-2:0];
            o_mosi  <= ld_c[BITS-1];
            o_cs    <= SLAVE_ID;
            o_busy  <= 1'b1;
            bit_cnt <= '0;
          end
        end
        WR, RD: begin
          if (rise_stb && (state == RD)) rx <= {rx[BITS-2:0], i_miso};
          if (frame_end_c) begin
            o_cs    <= '0;
            o_mosi  <= 1'b0;
            bit_cnt <= '0;
          end else if (fall_stb) begin
            o_mosi <= tx[BITS-2];
            tx     <= {tx[BITS-3:0], 1'b0};
          end
        end
        GAP: begin
          if (gap_end_c) begin
            o_cs    <= SLAVE_ID;
            tx      <= ld_c[BITS-2:0];
            o_mosi  <= ld_c[BITS-1];
            bit_cnt <= '0;
          end
        end
        DONE: begin
          o_result <= rx[RESULT_HI:RESULT_LO];
          o_flags  <= rx[FLAGS_HI:FLAGS_LO];
          o_err    <= (rx[ARGA_HI:OPER_LO] != echo);
          o_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_exe_master.sv
// Directed bench for spi_exe_master: default timing instance plus a CLK_DIV=1/GAP=2 instance.
module tb_spi_exe_master;
  import spi_exe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   fails  = 0;

  logic            start1, busy1, done1, err1, sclk1, mosi1, miso1;
  logic [3:0]      a1, b1, op1, result1, flags1;
  logic [CS_W-1:0] cs1;
  logic            start2, busy2, done2, err2, sclk2, mosi2, miso2;
  logic [3:0]      a2, b2, op2, result2, flags2;
  logic [CS_W-1:0] cs2;

  spi_exe_master #(.CLK_DIV(4), .GAP_CYCLES(3)) dut1 (
    .i_clk(clk), .i_rst(rst_n), .i_start(start1), .i_argA(a1), .i_argB(b1), .i_oper(op1),
    .o_busy(busy1), .o_done(done1), .o_result(result1), .o_flags(flags1), .o_err(err1),
    .o_sclk(sclk1), .o_mosi(mosi1), .i_miso(miso1), .o_cs(cs1));

  spi_exe_master #(.CLK_DIV(1), .GAP_CYCLES(2)) dut2 (
    .i_clk(clk), .i_rst(rst_n), .i_start(start2), .i_argA(a2), .i_argB(b2), .i_oper(op2),
    .o_busy(busy2), .o_done(done2), .o_result(result2), .o_flags(flags2), .o_err(err2),
    .o_sclk(sclk2), .o_mosi(mosi2), .i_miso(miso2), .o_cs(cs2));

  // Slave models: MISO presents response bit (19 - rises in window), MOSI captured on rises.
  logic [19:0] resp1, resp2;
  logic [39:0] mosi_sh1;
  int rises1 = 0, base1 = 0, gap1 = 0, rises2 = 0;

  always @(posedge sclk1) begin
    if (cs1 == SLAVE_ID) begin
      rises1   <= rises1 + 1;
      mosi_sh1 <= {mosi_sh1[38:0], mosi1};
    end else begin
      gap1 <= gap1 + 1;
    end
  end

  always @(posedge sclk2) if (cs2 == SLAVE_ID) rises2 <= rises2 + 1;

  always_comb begin
    int i1, i2;
    i1 = (rises1 - base1) % 20;
    i2 = rises2 % 20;
    miso1 = resp1[19 - i1];
    miso2 = resp2[19 - i2];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic txn1(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                      output int lat);
    a1 = a; b1 = b; op1 = op; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 1;
    while (!done1 && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic txn2(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                      output int lat);
    a2 = a; b2 = b; op2 = op; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    lat = 1;
    while (!done2 && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, n, r0, g0, dones, early;
    logic s;
    rst_n = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; op1 = '0;
    start2 = 1'b0; a2 = '0; b2 = '0; op2 = '0;
    resp1 = 20'h35181;
    resp2 = 20'hFF2E3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy1), 0);
    check("rst_done", 64'(done1), 0);
    check("rst_result", 64'(result1), 0);
    check("rst_flags", 64'(flags1), 0);
    check("rst_err", 64'(err1), 0);
    check("rst_sclk", 64'(sclk1), 0);
    check("rst_mosi", 64'(mosi1), 0);
    check("rst_cs", 64'(cs1), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted in the middle of the write frame.
    a1 = 4'h3; b1 = 4'h5; op1 = 4'h1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while ((rises1 - base1) < 7 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("midwr_reached", 64'(rises1 - base1), 7);
    rst_n = 1'b0;
    #1;
    check("midwr_sclk", 64'(sclk1), 0);
    check("midwr_cs", 64'(cs1), 0);
    check("midwr_mosi", 64'(mosi1), 0);
    check("midwr_busy", 64'(busy1), 0);
    r0 = rises1;
    repeat (20) @(posedge clk);
    #1;
    check("midwr_no_edges", 64'(rises1 - r0), 0);
    check("midwr_sclk_held", 64'(sclk1), 0);
    rst_n = 1'b1;
    base1 = rises1;
    @(posedge clk); #1;

    // Nominal request.
    r0 = rises1; g0 = gap1;
    txn1(4'h3, 4'h5, 4'h1, lat);
    check("nom_latency", 64'(lat), 346);
    check("nom_done", 64'(done1), 1);
    check("nom_busy_at_done", 64'(busy1), 1);
    check("nom_result", 64'(result1), 64'h8);
    check("nom_flags", 64'(flags1), 64'h1);
    check("nom_err", 64'(err1), 0);
    check("nom_rises", 64'(rises1 - r0), 40);
    check("nom_gap_periods", 64'(gap1 - g0), 3);
    check("nom_mosi_frames", 64'(mosi_sh1), {20'h35100, 20'h35100});
    check("nom_cs_after", 64'(cs1), 0);
    @(posedge clk); #1;
    check("nom_done_pulse", 64'(done1), 0);
    check("nom_busy_drop", 64'(busy1), 0);
    check("nom_result_hold", 64'(result1), 64'h8);

    // Echo mismatch from the slave.
    resp1 = 20'h36181;
    txn1(4'h3, 4'h5, 4'h1, lat);
    check("err_latency", 64'(lat), 346);
    check("err_err", 64'(err1), 1);
    check("err_result", 64'(result1), 64'h8);
    check("err_flags", 64'(flags1), 64'h1);
    @(posedge clk); #1;

    // i_start held high through a whole transaction.
    resp1 = 20'h35181;
    a1 = 4'h3; b1 = 4'h5; op1 = 4'h1; start1 = 1'b1;
    dones = 0; early = 0;
    for (int c = 1; c <= 346; c++) begin
      @(posedge clk); #1;
      if (done1) dones++;
      if (!busy1) early++;
    end
    check("hold_done_count", 64'(dones), 1);
    check("hold_busy_low_early", 64'(early), 0);
    check("hold_done_last", 64'(done1), 1);
    @(posedge clk); #1;
    check("hold_not_accepted_in_done", 64'(busy1), 0);
    @(posedge clk); #1;
    check("hold_second_accept", 64'(busy1), 1);
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_second_done", 64'(done1), 1);
    check("hold_second_result", 64'(result1), 64'h8);
    check("hold_second_err", 64'(err1), 0);
    @(posedge clk); #1;

    // Fast instance: CLK_DIV=1, GAP_CYCLES=2, back-to-back requests.
    r0 = rises2;
    txn2(4'hF, 4'hF, 4'h2, lat);
    check("fast_latency", 64'(lat), 86);
    check("fast_result", 64'(result2), 64'hE);
    check("fast_flags", 64'(flags2), 64'h3);
    check("fast_err", 64'(err2), 0);
    check("fast_rises", 64'(rises2 - r0), 40);
    @(posedge clk); #1;
    check("fast_busy_drop", 64'(busy2), 0);
    a2 = 4'hF; b2 = 4'hF; op2 = 4'h2; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("fast_hold_result", 64'(result2), 64'hE);
    check("fast_hold_flags", 64'(flags2), 64'h3);
    check("fast_busy_mid", 64'(busy2), 1);
    s = sclk2;
    @(posedge clk); #1;
    check("fast_sclk_toggle", 64'(sclk2), 64'(!s));
    n = 0;
    while (!done2 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("fast2_done", 64'(done2), 1);
    check("fast2_result", 64'(result2), 64'hE);
    check("fast2_flags", 64'(flags2), 64'h3);
    check("fast2_err", 64'(err2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
